sdio_cmd_capture: RTL and testbench

// - Upstream capture stage for the SDIO CMD line. Oversamples sd_clk/cmd_i in the system clock

---
 rtl/sdio_cmd_capture_if.sv | 21 ++
 rtl/sdio_cmd_capture.sv | 164 ++++++++++++++++
 tb/tb_sdio_cmd_capture.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sdio_cmd_capture_if.sv
// SDIO CMD capture bus: raw SDIO line inputs plus the deframed command towards the ctrl block.
interface sdio_cmd_capture_if;
    logic        sd_en;
    logic        sd_clk;
    logic        cmd_i;
    logic [7:0]  cmd_o;
    logic [31:0] arg_o;
    logic [6:0]  crc_o;
    logic        finsh_o;
    logic [7:0]  status;

    modport master (
        output sd_en, sd_clk, cmd_i,
        input  cmd_o, arg_o, crc_o, finsh_o, status
    );

    modport slave (
        input  sd_en, sd_clk, cmd_i,
        output cmd_o, arg_o, crc_o, finsh_o, status
    );
endinterface

// File: rtl/sdio_cmd_capture.sv
// Oversamples the SDIO CMD line in the system clock domain and deframes 48-bit host commands,
// checking CRC7 and the end bit, then strobes finsh_o with the captured fields.
module sdio_cmd_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CRC_CHECK   = 1
) (
    input  logic               clk,
    input  logic               rst,
    sdio_cmd_capture_if.slave  bus
);
    localparam int unsigned FRAME_W  = 48;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned CRC_W    = 7;
    localparam int unsigned FCNT_W   = 4;
    localparam int unsigned LAST_BIT = 47;
    localparam int unsigned CRC_LAST = 39;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cmd_sync_q,  cmd_sync_d;
    logic                   sclk_dly_q,  sclk_dly_d;

    state_e              state_q,     state_d;
    logic [FRAME_W-1:0]  shreg_q,     shreg_d;
    logic [CNT_W-1:0]    bitcnt_q,    bitcnt_d;
    logic [CRC_W-1:0]    crc_q,       crc_d;
    logic [7:0]          cmd_q,       cmd_d;
    logic [31:0]         arg_q,       arg_d;
    logic [CRC_W-1:0]    crc_rx_q,    crc_rx_d;
    logic                finsh_q,     finsh_d;
    logic                crc_err_q,   crc_err_d;
    logic                end_err_q,   end_err_d;
    logic                dir_q,       dir_d;
    logic                busy_q,      busy_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic sd_rise_c;
    logic bit_c;

    // CRC7, polynomial x^7 + x^3 + 1, MSB-first serial update
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = b ^ c[CRC_W-1];
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sd_clk};
        cmd_sync_d  = {cmd_sync_q[SYNC_STAGES-2:0],  bus.cmd_i};
        sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
        sd_rise_c   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
        bit_c       = cmd_sync_q[SYNC_STAGES-1];
    end

    // Deframing FSM and output capture
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        crc_d       = crc_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        crc_rx_d    = crc_rx_q;
        finsh_d     = 1'b0;
        crc_err_d   = crc_err_q;
        end_err_d   = end_err_q;
        dir_d       = dir_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sd_rise_c && !bit_c && bus.sd_en) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = {(FRAME_W-1)'(0), bit_c};
                    bitcnt_d = CNT_W'(1);
                    crc_d    = crc7_step(CRC_W'(0), bit_c);
                end
            end
            ST_SHIFT: begin
                if (!bus.sd_en) begin
                    state_d  = ST_IDLE;
                    bitcnt_d = CNT_W'(0);
                end else if (sd_rise_c) begin
                    shreg_d  = {shreg_q[FRAME_W-2:0], bit_c};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q <= CNT_W'(CRC_LAST)) begin
                        crc_d = crc7_step(crc_q, bit_c);
                    end
                    // End bit arrives: latch fields so finsh_o and outputs appear together
                    if (bitcnt_q == CNT_W'(LAST_BIT)) begin
                        state_d     = ST_DONE;
                        bitcnt_d    = CNT_W'(0);
                        cmd_d       = shreg_d[47:40];
                        arg_d       = shreg_d[39:8];
                        crc_rx_d    = shreg_d[7:1];
                        crc_err_d   = 1'(CRC_CHECK) & (crc_q != shreg_d[7:1]);
                        end_err_d   = ~shreg_d[0];
                        dir_d       = shreg_d[46];
                        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                        finsh_d     = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cmd_sync_q  <= '0;
            sclk_dly_q  <= 1'b0;
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            crc_q       <= '0;
            cmd_q       <= '0;
            arg_q       <= '0;
            crc_rx_q    <= '0;
            finsh_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            end_err_q   <= 1'b0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cmd_sync_q  <= cmd_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            crc_q       <= crc_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            crc_rx_q    <= crc_rx_d;
            finsh_q     <= finsh_d;
            crc_err_q   <= crc_err_d;
            end_err_q   <= end_err_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.cmd_o   = cmd_q;
    assign bus.arg_o   = arg_q;
    assign bus.crc_o   = crc_rx_q;
    assign bus.finsh_o = finsh_q;
    assign bus.status  = {frame_cnt_q, busy_q, dir_q, end_err_q, crc_err_q};

endmodule

// File: tb/tb_sdio_cmd_capture.sv
// Scoreboard bench for sdio_cmd_capture: directed SDIO frames at sd_clk = clk/8, with a second
// instance built with CRC_CHECK=0 fed from the same lines.
module tb_sdio_cmd_capture;
    logic clk;
    logic rst;

    sdio_cmd_capture_if bus();
    sdio_cmd_capture_if nc_bus();

    assign nc_bus.sd_en  = bus.sd_en;
    assign nc_bus.sd_clk = bus.sd_clk;
    assign nc_bus.cmd_i  = bus.cmd_i;

    sdio_cmd_capture #(.SYNC_STAGES(2), .CRC_CHECK(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sdio_cmd_capture #(.SYNC_STAGES(2), .CRC_CHECK(0)) u_dut_nc (
        .clk (clk),
        .rst (rst),
        .bus (nc_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic [7:0]  status;
    } exp_t;

    exp_t       q[$];
    exp_t       q_nc[$];
    exp_t       e_mon;
    exp_t       e_mon_nc;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_cnt = 4'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Main monitor: every finsh_o must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.finsh_o === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_finsh", 64'(1), 64'(0));
            end else begin
                e_mon = q.pop_front();
                chk("cmd_o",  64'(bus.cmd_o),  64'(e_mon.cmd));
                chk("arg_o",  64'(bus.arg_o),  64'(e_mon.arg));
                chk("crc_o",  64'(bus.crc_o),  64'(e_mon.crc));
                chk("status", 64'(bus.status), 64'(e_mon.status));
            end
        end
    end

    always @(negedge clk) begin
        if (nc_bus.finsh_o === 1'b1) begin
            if (q_nc.size() == 0) begin
                chk("nc_unexpected_finsh", 64'(1), 64'(0));
            end else begin
                e_mon_nc = q_nc.pop_front();
                chk("nc_cmd_o",  64'(nc_bus.cmd_o),  64'(e_mon_nc.cmd));
                chk("nc_status", 64'(nc_bus.status), 64'(e_mon_nc.status));
            end
        end
    end

    // Drive MSB-first bits; the end bit's finsh_o must land 3 negedges after sd_clk rises
    task automatic send_bits(input logic [47:0] f, input int nbits, input bit check_lat);
        for (int i = 0; i < nbits; i++) begin
            bus.cmd_i = f[47-i];
            repeat (4) @(negedge clk);
            bus.sd_clk = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (check_lat && i == 47) begin
                    chk("finsh_latency", 64'(bus.finsh_o), 64'(k == 3));
                end
            end
            bus.sd_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [47:0] f, input logic crc_bad);
        exp_t e;
        exp_cnt  = exp_cnt + 4'd1;
        e.cmd    = f[47:40];
        e.arg    = f[39:8];
        e.crc    = f[7:1];
        e.status = {exp_cnt, 1'b1, f[46], ~f[0], crc_bad};
        q.push_back(e);
        e.status[0] = 1'b0;
        q_nc.push_back(e);
        send_bits(f, 48, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cmd_o"},   64'(bus.cmd_o),   64'(0));
        chk({tag, "_arg_o"},   64'(bus.arg_o),   64'(0));
        chk({tag, "_crc_o"},   64'(bus.crc_o),   64'(0));
        chk({tag, "_finsh_o"}, 64'(bus.finsh_o), 64'(0));
        chk({tag, "_status"},  64'(bus.status),  64'(0));
        chk({tag, "_nc_status"}, 64'(nc_bus.status), 64'(0));
    endtask

    logic [47:0] cmd0, cmd8, cmd8_bad, cmd0_badend, idle_ones;

    initial begin
        cmd0        = 48'h40_0000_0000_95;
        cmd8        = 48'h48_0000_01AA_87;
        cmd8_bad    = 48'h48_0000_01AA_89;
        cmd0_badend = 48'h40_0000_0000_94;
        idle_ones   = 48'hFFFF_FFFF_FFFF;

        rst        = 1'b1;
        bus.sd_en  = 1'b1;
        bus.sd_clk = 1'b0;
        bus.cmd_i  = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Idle-level ones are not frames
        send_bits(idle_ones, 8, 1'b0);
        send_frame(cmd0, 1'b0);
        send_frame(cmd8, 1'b0);
        send_frame(cmd8_bad, 1'b1);
        send_frame(cmd0_badend, 1'b0);
        repeat (20) @(negedge clk);
        chk("hold_cmd_o",   64'(bus.cmd_o),   64'(8'h40));
        chk("hold_end_err", 64'(bus.status[1]), 64'(1));
        chk("hold_busy",    64'(bus.status[3]), 64'(0));
        chk("hold_cnt",     64'(bus.status[7:4]), 64'(4));

        // Abort after 20 bits, then a clean CMD0 from reset state
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 4'd0;
        repeat (2) @(negedge clk);
        send_bits(cmd0, 20, 1'b0);
        @(negedge clk);
        chk("abort_busy_before", 64'(bus.status[3]), 64'(1));
        bus.sd_en = 1'b0;
        bus.cmd_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_busy_after", 64'(bus.status[3]), 64'(0));
        chk("abort_hold_cmd",   64'(bus.cmd_o),     64'(0));
        bus.sd_en = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(cmd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_cnt", 64'(bus.status[7:4]), 64'(1));

        // Reset mid-frame discards the partial frame
        send_bits(cmd8, 20, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        exp_cnt = 4'd0;
        bus.cmd_i = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back frames wrap frame_cnt
        for (int n = 0; n < 17; n++) begin
            send_frame(cmd0, 1'b0);
        end
        repeat (10) @(negedge clk);
        chk("wrap_cnt",      64'(bus.status[7:4]), 64'(1));
        chk("queue_drained", 64'(q.size()),        64'(0));
        chk("nc_queue_drained", 64'(q_nc.size()),  64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
